// File: rtl/peran_pkg.sv
// Shared definitions for the PEran job scheduler: datapath widths and the
// scheduler FSM state encoding.
package peran_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned MAT_W         = 160;
  localparam int unsigned NUCL_W        = 2;
  localparam int unsigned NUCL_PER_WORD = WORD_W / NUCL_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/peran_valid_pipe.sv
// Valid-bit shift register tracking words between read strobe and write.
// Its output is the write strobe and the write-index increment.
module peran_valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic [DEPTH-1:0] stages,
  output logic             valid_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], valid_in};
    end
  end

  assign valid_out = stages[DEPTH-1];

endmodule

// File: rtl/peran_job_scheduler.sv
// Streams one job of parent words from source RAM through PEran into destination RAM.
// Optional job cycle counter enabled by defining PERAN_SCHED_PERF_EN.
module peran_job_scheduler
  import peran_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WORD_W = peran_pkg::WORD_W,
  parameter int unsigned MAT_W  = peran_pkg::MAT_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned PE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   num_words,
  input  logic [MAT_W-1:0]  matrix_P_in,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic [WORD_W-1:0] pe_nucl_alig,
  output logic [MAT_W-1:0]  pe_matrix_P,
  input  logic [WORD_W-1:0] pe_final_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data
`ifdef PERAN_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int unsigned DEPTH = RD_LAT + 1 + PE_LAT;

  sched_state_e state_q, state_d;

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   num_q;
  logic [MAT_W-1:0]  mat_q;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [DEPTH-1:0]  stages;
  logic              wr_inc;
  logic              accept;
  logic              load;
  logic              last_rd;

  assign last_rd = (rd_cnt + (ADDR_W+1)'(1)) == num_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    accept  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        load    = 1'b1;
        state_d = (num_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave once only the output stage can still be set: DONE then
        // coincides with the final write instead of trailing it.
        if (stages[DEPTH-3:0] == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  peran_valid_pipe #(
    .DEPTH(DEPTH)
  ) u_valid_pipe (
    .clk      (clk),
    .reset    (reset),
    .valid_in (rd_en),
    .stages   (stages),
    .valid_out(wr_inc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q        <= '0;
      dst_q        <= '0;
      num_q        <= '0;
      mat_q        <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      pe_nucl_alig <= '0;
      pe_matrix_P  <= '0;
    end else begin
      if (accept) begin
        src_q  <= src_base;
        dst_q  <= dst_base;
        num_q  <= num_words;
        mat_q  <= matrix_P_in;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (load) pe_matrix_P <= mat_q;
      if (rd_en) rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
      if (stages[RD_LAT-1]) pe_nucl_alig <= rd_data;
      if (wr_inc) wr_cnt <= wr_cnt + ADDR_W'(1);
    end
  end

  assign rd_addr = src_q + rd_cnt[ADDR_W-1:0];
  assign wr_addr = dst_q + wr_cnt;
  assign wr_en   = wr_inc;
  assign wr_data = pe_final_result;

`ifdef PERAN_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_peran_job_scheduler.sv
// Scoreboard bench for peran_job_scheduler: source RAM and echoing PEran models,
// expected reads/writes queued at job issue and checked by a negedge monitor.
module tb_peran_job_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   src_base = '0;
  logic [9:0]   dst_base = '0;
  logic [10:0]  num_words = '0;
  logic [159:0] matrix_P_in = '0;
  logic         busy, done, rd_en, wr_en;
  logic [9:0]   rd_addr, wr_addr;
  logic [31:0]  rd_data = '0;
  logic [31:0]  pe_nucl_alig, pe_final_result = '0, wr_data;
  logic [159:0] pe_matrix_P;
`ifdef PERAN_SCHED_PERF_EN
  logic [31:0]  perf_cycles;
`endif

  peran_job_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src_base       (src_base),
    .dst_base       (dst_base),
    .num_words      (num_words),
    .matrix_P_in    (matrix_P_in),
    .busy           (busy),
    .done           (done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .pe_nucl_alig   (pe_nucl_alig),
    .pe_matrix_P    (pe_matrix_P),
    .pe_final_result(pe_final_result),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data)
`ifdef PERAN_SCHED_PERF_EN
    ,
    .perf_cycles    (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source RAM (1-cycle read) and a PEran stand-in that echoes nucl_alig after 1 cycle.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    pe_final_result <= pe_nucl_alig;
  end

  logic [9:0]  exp_rd[$];
  logic [41:0] exp_wr[$];
  int          rd_times[$];
  logic [41:0] e;
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (rd_en) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got read at %0h expected none", rd_addr);
        end else begin
          chk("rd_addr", rd_addr, exp_rd.pop_front());
        end
        rd_times.push_back(cyc);
      end
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got write at %0h expected none", wr_addr);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", wr_addr, e[41:32]);
          chk("wr_data", wr_data, e[31:0]);
        end
        if (rd_times.size() != 0) chk("rd_to_wr_latency", cyc - rd_times.pop_front(), 3);
      end
      if (done) chk("busy_low_at_done", busy, 0);
    end
  end

  task automatic run_job(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                         input logic [159:0] p, input bit repulse,
                         output int busy_cnt, output int done_rel, output int done_cnt,
                         output int p_bad);
    int c0;
    logic [9:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a = s + 10'(i);
      exp_rd.push_back(a);
      exp_wr.push_back({d + 10'(i), mem[a]});
    end
    @(posedge clk); #1;
    start = 1'b1; src_base = s; dst_base = d; num_words = n; matrix_P_in = p;
    c0 = cyc;
    busy_cnt = 0; done_rel = -1; done_cnt = 0; p_bad = 0;
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      if (cyc == c0 + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (cyc >= c0 + 2 && (busy || done) && pe_matrix_P !== p) p_bad++;
      if (repulse && cyc == c0 + 4) begin
        start = 1'b1; matrix_P_in = ~p; src_base = ~s;
      end
      if (repulse && cyc == c0 + 5) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = cyc - c0;
        if (repulse) start = 1'b1;
      end else if (repulse && done_rel >= 0) begin
        start = 1'b0;
      end
      if (done_rel >= 0 && cyc >= c0 + done_rel + 6) break;
    end
    start = 1'b0;
  endtask

  task automatic job_check(input string name, input logic [9:0] s, input logic [9:0] d,
                           input logic [10:0] n, input logic [159:0] p, input bit repulse);
    int b, r, dc, pb, exp_busy;
    exp_busy = (n == 0) ? 1 : int'(n) + 3;
    run_job(s, d, n, p, repulse, b, r, dc, pb);
    chk({name, "_busy_cycles"}, b, exp_busy);
    chk({name, "_done_cycle"}, r, exp_busy + 1);
    chk({name, "_done_count"}, dc, 1);
    chk({name, "_matrix_stable"}, pb, 0);
    chk({name, "_rd_drained"}, exp_rd.size(), 0);
    chk({name, "_wr_drained"}, exp_wr.size(), 0);
  endtask

  logic [159:0] p_id, p_alt;
  int c0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {8'hA5, 8'(i * 7), 6'b0, 10'(i)};
    p_id = '0;
    for (int r = 0; r < 4; r++) p_id[(r * 4 + r) * 10 +: 10] = 10'h3FF;
    p_alt = {5{32'hDEADBEEF}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_nucl", pe_nucl_alig, 0);
    chk("rst_matrix", pe_matrix_P, 0);
    reset = 1'b1;

    job_check("basic4", 10'h010, 10'h100, 11'd4, p_id, 1'b0);
    job_check("zero", 10'h055, 10'h155, 11'd0, p_id, 1'b0);
    job_check("wrap4", 10'h3FE, 10'h3FE, 11'd4, p_alt, 1'b0);
    job_check("single", 10'h200, 10'h300, 11'd1, p_id, 1'b0);
    job_check("repulse6", 10'h020, 10'h140, 11'd6, p_alt, 1'b1);

`ifdef PERAN_SCHED_PERF_EN
    job_check("perf16", 10'h040, 10'h180, 11'd16, p_id, 1'b0);
    chk("perf_hold", perf_cycles, 19);
    job_check("perf0", 10'h000, 10'h000, 11'd0, p_id, 1'b0);
    chk("perf_restart", perf_cycles, 1);
`endif

    // Reset in the middle of an 8-word job, after its third read.
    for (int i = 0; i < 3; i++) exp_rd.push_back(10'h080 + 10'(i));
    @(posedge clk); #1;
    start = 1'b1; src_base = 10'h080; dst_base = 10'h1C0; num_words = 11'd8;
    matrix_P_in = p_alt;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_cycle", cyc, c0 + 5);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_nucl", pe_nucl_alig, 0);
    chk("midrst_matrix", pe_matrix_P, 0);
    chk("midrst_reads_seen", exp_rd.size(), 0);
    rd_times.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_idle_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
